pool_unit: RTL and testbench
============================

POOL_UNIT -- requirements
Module: pool_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, element width in bits (>=2).
REQ-002 SHALL have parameter LANES, default 4, elements per input word, i.e. pooling window; power of two, >=2; LOG2L = log2(LANES).
REQ-003 SHALL have parameter SIGNED, default 0, 1 = two's-complement elements, 0 = unsigned.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- DIN  in  DATA_W*LANES  input word; lane k = DIN[k*DATA_W +: DATA_W].
- DIN_VLD  in  1  input valid.
- DIN_RDY  out  1  input ready.
- DOUT  out  DATA_W*LANES  output word.
- DOUT_VLD  out  1  output valid.
- DOUT_RDY  in  1  downstream ready.
- OP_START  in  1  start pulse.
- OP_CLEAR  in  1  clear pulse.
- POOL_USE  in  1  1 = pool, 0 = bypass; sampled on OP_START only.
- POOL_MODE  in  1  0 = max, 1 = average; sampled on OP_START only.
- OUT_CNT  out  32  pooled results delivered since last OP_START.

Function
REQ-005 SHALL implement states IDLE, BYPASS, POOL; transfer occurs when VLD and RDY are both high at a rising edge.
REQ-006 In IDLE, OP_START SHALL go to POOL if POOL_USE=1, else BYPASS, and SHALL latch POOL_MODE.
REQ-007 OP_CLEAR in any state SHALL return to IDLE next cycle and SHALL win over a simultaneous OP_START.
REQ-008 OP_START outside IDLE SHALL be ignored; latched mode SHALL be stable until next accepted OP_START.
REQ-009 IDLE: DIN_RDY=0, DOUT_VLD=0, DOUT=0.
REQ-010 BYPASS: DOUT=DIN, DOUT_VLD=DIN_VLD, DIN_RDY=DOUT_RDY, all combinational, zero latency; OUT_CNT unchanged.
REQ-011 POOL: reduction SHALL be a tree of LOG2L registered stages, each halving the operand count, each stage with its own valid bit.
REQ-012 Pipeline enable en = ~DOUT_VLD | DOUT_RDY; all stages advance together when en=1, hold when en=0; DIN_RDY = (state==POOL) & en.
REQ-013 Latency SHALL be exactly LOG2L cycles from input transfer to DOUT_VLD with no stall; throughput one word per cycle.
REQ-014 Max mode: each node outputs larger operand, compared signed iff SIGNED=1; ties yield that value.
REQ-015 Average mode: tree SHALL sum at full width DATA_W+LOG2L (sign-extended iff SIGNED); result = sum arithmetically (SIGNED) or logically shifted right by LOG2L, truncated to DATA_W (floor rounding).
REQ-016 POOL output: DOUT[DATA_W-1:0] = result, upper bits 0; DOUT_VLD = last-stage valid.
REQ-017 OUT_CNT SHALL increment on each POOL output transfer, wrap 0xFFFFFFFF->0, clear to 0 on accepted OP_START.
REQ-018 OP_CLEAR SHALL invalidate all stage valid bits next cycle; in-flight results discarded, not output.
REQ-019 Result order SHALL equal input order; no loss or duplication under any DOUT_RDY pattern.

Reset
REQ-020 rst high SHALL immediately force state=IDLE, all valid bits 0, stage data 0, latched mode 0, OUT_CNT 0; hence DIN_RDY=0, DOUT_VLD=0, DOUT=0.
REQ-021 Reset mid-operation SHALL discard in-flight data; operation resumes only after new OP_START.

Verification (DATA_W=16, LANES=4)
REQ-022 SIGNED=0, max, DIN=0x0001_0009_0003_0007, DOUT_RDY=1 -> DOUT_VLD 2 cycles after transfer, DOUT=0x...0009, OUT_CNT=1.
REQ-023 SIGNED=1, max, lanes 0xFFFF,0x8000,0xFFFE,0x8001 -> 0xFFFF; average, lanes 0xFFFF,0xFFFE,0,0 -> 0xFFFF (-3>>2=-1); SIGNED=0 average 4,5,6,7 -> 0x0005.
REQ-024 POOL, DIN_VLD=1 with 5 distinct words, DOUT_RDY low 6 cycles then high -> DIN_RDY drops once DOUT_VLD=1, 5 results out in order, OUT_CNT=5.
REQ-025 BYPASS, DIN=0x1234_5678_9ABC_DEF0, toggle DOUT_RDY -> DOUT equals DIN same cycle, DIN_RDY tracks DOUT_RDY, OUT_CNT=0.
REQ-026 OP_CLEAR and OP_START same cycle in IDLE -> stays IDLE; OP_CLEAR with 2 words in flight -> no DOUT_VLD afterwards, IDLE next cycle.
REQ-027 rst asserted mid-stream -> DOUT_VLD, DIN_RDY, OUT_CNT 0 immediately; no output until new OP_START.

Source files
------------

// File: rtl/pool_unit_if.sv
// Stream and control bundle for pool_unit: one input word stream, one output
// word stream, and the start/clear/mode control pulses with the result counter.
interface pool_unit_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
);
  // Handshake: a word moves on a rising clk edge where VLD and RDY are both
  // high; a source holds its word and VLD until that edge, and a sink may
  // raise or drop RDY in any cycle.
  logic [DATA_W*LANES-1:0] DIN;
  logic                    DIN_VLD;
  logic                    DIN_RDY;
  logic [DATA_W*LANES-1:0] DOUT;
  logic                    DOUT_VLD;
  logic                    DOUT_RDY;
  logic                    OP_START;
  logic                    OP_CLEAR;
  logic                    POOL_USE;
  logic                    POOL_MODE;
  logic [31:0]             OUT_CNT;

  modport slave (
    input  DIN, DIN_VLD, DOUT_RDY, OP_START, OP_CLEAR, POOL_USE, POOL_MODE,
    output DIN_RDY, DOUT, DOUT_VLD, OUT_CNT
  );

  modport master (
    output DIN, DIN_VLD, DOUT_RDY, OP_START, OP_CLEAR, POOL_USE, POOL_MODE,
    input  DIN_RDY, DOUT, DOUT_VLD, OUT_CNT
  );
endinterface

// File: rtl/pool_unit.sv
// Lane pooling engine: reduces the LANES elements of each input word to one
// element (max or floor-average) through a registered binary tree, or bypasses.
module pool_unit #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  pool_unit_if.slave  bus,
  output logic [1:0]  o_dbg_state
);

  localparam int LOG2L = $clog2(LANES);
  localparam int SW    = DATA_W + LOG2L;
  localparam int WW    = DATA_W * LANES;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYPASS = 2'd1,
    S_POOL   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_mode;
  logic [31:0]         r_cnt;
  logic                w_en;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_last_v;
  logic [SW-1:0]       w_last_d;
  logic [DATA_W-1:0]   w_res;

  // Operands carry LOG2L guard bits so the average tree never overflows.
  function automatic logic [SW-1:0] f_ext(input logic [DATA_W-1:0] x);
    if (SIGNED) return {{LOG2L{x[DATA_W-1]}}, x};
    else        return {{LOG2L{1'b0}}, x};
  endfunction

  function automatic logic [SW-1:0] f_node(input logic [SW-1:0] a,
                                           input logic [SW-1:0] b,
                                           input logic          avg);
    logic gt;
    if (SIGNED) gt = ($signed(a) > $signed(b));
    else        gt = (a > b);
    if (avg) return a + b;
    else     return gt ? a : b;
  endfunction

  assign w_start_ok = (r_state == S_IDLE) & bus.OP_START & ~bus.OP_CLEAR;
  assign w_en       = ~w_last_v | bus.DOUT_RDY;
  assign w_accept   = (r_state == S_POOL) & bus.DIN_VLD & w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.OP_CLEAR)    w_state_nxt = S_IDLE;
    else if (w_start_ok) w_state_nxt = bus.POOL_USE ? S_POOL : S_BYPASS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_mode <= 1'b0;
    else if (w_start_ok) r_mode <= bus.POOL_MODE;
  end

  // Tree stage g holds LANES >> (g+1) partial results and one valid bit.
  for (genvar g = 0; g < LOG2L; g++) begin : g_stg
    localparam int N = LANES >> (g + 1);
    logic [SW-1:0] w_in [2*N];
    logic          w_vin;
    logic [SW-1:0] r_d  [N];
    logic          r_v;

    if (g == 0) begin : g_src
      for (genvar k = 0; k < 2*N; k++) begin : g_lane
        assign w_in[k] = f_ext(bus.DIN[k*DATA_W +: DATA_W]);
      end
      assign w_vin = w_accept;
    end else begin : g_src
      for (genvar k = 0; k < 2*N; k++) begin : g_lane
        assign w_in[k] = g_stg[g-1].r_d[k];
      end
      assign w_vin = g_stg[g-1].r_v;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        for (int k = 0; k < N; k++) r_d[k] <= '0;
      end else if (bus.OP_CLEAR) begin
        r_v <= 1'b0;
      end else if (w_en) begin
        r_v <= w_vin;
        for (int k = 0; k < N; k++) r_d[k] <= f_node(w_in[2*k], w_in[2*k+1], r_mode);
      end
    end
  end

  assign w_last_v = g_stg[LOG2L-1].r_v;
  assign w_last_d = g_stg[LOG2L-1].r_d[0];
  // Dropping the low LOG2L bits of the sum is a floor divide for both signednesses.
  assign w_res    = r_mode ? w_last_d[SW-1:LOG2L] : w_last_d[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  r_cnt <= '0;
    else if (w_start_ok)                                      r_cnt <= '0;
    else if ((r_state == S_POOL) && w_last_v && bus.DOUT_RDY) r_cnt <= r_cnt + 32'd1;
  end

  always_comb begin
    bus.DIN_RDY  = 1'b0;
    bus.DOUT_VLD = 1'b0;
    bus.DOUT     = '0;
    case (r_state)
      S_BYPASS: begin
        bus.DIN_RDY  = bus.DOUT_RDY;
        bus.DOUT_VLD = bus.DIN_VLD;
        bus.DOUT     = bus.DIN;
      end
      S_POOL: begin
        bus.DIN_RDY  = w_en;
        bus.DOUT_VLD = w_last_v;
        bus.DOUT     = {{(WW-DATA_W){1'b0}}, w_res};
      end
      default: ;
    endcase
  end

  assign bus.OUT_CNT = r_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pool_unit.sv
// Bench for pool_unit: unsigned and signed instances share one stimulus stream
// and are checked every cycle against a transaction-level reference model.
module tb_pool_unit;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int LG = 2;
  localparam int WW = DW * LN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [WW-1:0] din       = '0;
  logic          din_vld   = 1'b0;
  logic          dout_rdy  = 1'b0;
  logic          op_start  = 1'b0;
  logic          op_clear  = 1'b0;
  logic          pool_use  = 1'b0;
  logic          pool_mode = 1'b0;
  logic [1:0]    dbg_u;
  logic [1:0]    dbg_s;

  pool_unit_if #(.DATA_W(DW), .LANES(LN)) bus_u ();
  pool_unit_if #(.DATA_W(DW), .LANES(LN)) bus_s ();

  assign bus_u.DIN = din;       assign bus_s.DIN = din;
  assign bus_u.DIN_VLD = din_vld;   assign bus_s.DIN_VLD = din_vld;
  assign bus_u.DOUT_RDY = dout_rdy; assign bus_s.DOUT_RDY = dout_rdy;
  assign bus_u.OP_START = op_start; assign bus_s.OP_START = op_start;
  assign bus_u.OP_CLEAR = op_clear; assign bus_s.OP_CLEAR = op_clear;
  assign bus_u.POOL_USE = pool_use; assign bus_s.POOL_USE = pool_use;
  assign bus_u.POOL_MODE = pool_mode; assign bus_s.POOL_MODE = pool_mode;

  pool_unit #(.DATA_W(DW), .LANES(LN), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .bus(bus_u), .o_dbg_state(dbg_u)
  );
  pool_unit #(.DATA_W(DW), .LANES(LN), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .o_dbg_state(dbg_s)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_pool(input logic [WW-1:0] w, input bit sgn, input bit avg);
    int v [LN];
    int best;
    int sum;
    logic [DW-1:0] lane;
    for (int i = 0; i < LN; i++) begin
      lane = w[i*DW +: DW];
      v[i] = sgn ? int'($signed(lane)) : int'({16'd0, lane});
    end
    best = v[0];
    sum  = 0;
    for (int i = 0; i < LN; i++) begin
      if (v[i] > best) best = v[i];
      sum += v[i];
    end
    if (avg) return DW'(sum >>> LG);
    else     return DW'(best);
  endfunction

  // Model: 0 idle, 1 bypass, 2 pool; m_v is the LOG2L-deep latency line.
  int              m_state = 0;
  bit              m_mode  = 1'b0;
  bit              m_v [LG];
  logic [31:0]     m_cnt   = '0;
  logic [DW-1:0]   exp_q0 [$];
  logic [DW-1:0]   exp_q1 [$];

  task automatic model_reset();
    m_state = 0;
    m_mode  = 1'b0;
    m_cnt   = '0;
    for (int k = 0; k < LG; k++) m_v[k] = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic          e_rdy;
    logic          e_vld;
    logic [WW-1:0] e_d0;
    logic [WW-1:0] e_d1;
    bit            dchk;
    bit            xin;
    bit            xout;
    bit            en;
    if (rst) model_reset();
    e_rdy = 1'b0; e_vld = 1'b0; e_d0 = '0; e_d1 = '0; dchk = 1'b1;
    case (m_state)
      1: begin e_rdy = dout_rdy; e_vld = din_vld; e_d0 = din; e_d1 = din; end
      2: begin
        e_vld = m_v[LG-1];
        e_rdy = !e_vld || dout_rdy;
        dchk  = e_vld;
        if (e_vld && (exp_q0.size() == 0 || exp_q1.size() == 0)) begin
          fail_now("exp_q_underflow");
          dchk = 1'b0;
        end else if (e_vld) begin
          e_d0 = {48'd0, exp_q0[0]};
          e_d1 = {48'd0, exp_q1[0]};
        end
      end
      default: ;
    endcase
    chk("din_rdy_u", bus_u.DIN_RDY, e_rdy);
    chk("din_rdy_s", bus_s.DIN_RDY, e_rdy);
    chk("dout_vld_u", bus_u.DOUT_VLD, e_vld);
    chk("dout_vld_s", bus_s.DOUT_VLD, e_vld);
    chk("out_cnt_u", bus_u.OUT_CNT, m_cnt);
    chk("out_cnt_s", bus_s.OUT_CNT, m_cnt);
    if (dchk) begin
      chk("dout_u", bus_u.DOUT, e_d0);
      chk("dout_s", bus_s.DOUT, e_d1);
    end
    if (!rst) begin
      xin  = (m_state == 2) && din_vld && e_rdy;
      xout = (m_state == 2) && e_vld && dout_rdy;
      if (xout && exp_q0.size() > 0) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (xin) begin
        exp_q0.push_back(ref_pool(din, 1'b0, m_mode));
        exp_q1.push_back(ref_pool(din, 1'b1, m_mode));
      end
      en = !m_v[LG-1] || dout_rdy;
      if (en) begin
        for (int k = LG-1; k > 0; k--) m_v[k] = m_v[k-1];
        m_v[0] = xin;
      end
      if (op_clear) begin
        m_state = 0;
        for (int k = 0; k < LG; k++) m_v[k] = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
      end else if (m_state == 0 && op_start) begin
        m_state = pool_use ? 2 : 1;
        m_mode  = pool_mode;
        m_cnt   = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit use_pool, input bit mode);
    op_start = 1'b1; pool_use = use_pool; pool_mode = mode;
    tick();
    op_start = 1'b0;
  endtask

  task automatic do_clear();
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
  endtask

  // Sends one word into an empty pipeline and returns the outputs and latency.
  task automatic send_and_get(input logic [WW-1:0] w, output logic [WW-1:0] d_u,
                              output logic [WW-1:0] d_s, output int lat);
    din = w; din_vld = 1'b1; dout_rdy = 1'b1;
    tick();
    din_vld = 1'b0;
    lat = 0;
    while (!bus_u.DOUT_VLD && lat < 10) begin
      tick();
      lat++;
    end
    if (lat >= 10) fail_now("send_and_get_timeout");
    d_u = bus_u.DOUT;
    d_s = bus_s.DOUT;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WW-1:0] d_u;
    logic [WW-1:0] d_s;
    logic [WW-1:0] words [5];
    int lat;
    int idx;
    bit acc;

    chk("model_max_u", ref_pool(64'h0001_0009_0003_0007, 1'b0, 1'b0), 64'h9);
    chk("model_max_s", ref_pool(64'h8001_FFFE_8000_FFFF, 1'b1, 1'b0), 64'hFFFF);
    chk("model_avg_s", ref_pool(64'h0000_0000_FFFE_FFFF, 1'b1, 1'b1), 64'hFFFF);
    chk("model_avg_u", ref_pool(64'h0007_0006_0005_0004, 1'b0, 1'b1), 64'h5);

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Unsigned max, latency and count
    do_start(1'b1, 1'b0);
    send_and_get(64'h0001_0009_0003_0007, d_u, d_s, lat);
    chk("req022_dout", d_u, 64'h9);
    chk("req022_lat", 64'(lat), 64'd1);
    chk("req022_cnt", bus_u.OUT_CNT, 64'd1);
    send_and_get(64'h8001_FFFE_8000_FFFF, d_u, d_s, lat);
    chk("req023_smax", d_s, 64'hFFFF);

    // Average mode
    do_clear();
    do_start(1'b1, 1'b1);
    send_and_get(64'h0000_0000_FFFE_FFFF, d_u, d_s, lat);
    chk("req023_savg", d_s, 64'hFFFF);
    chk("req023_uavg_big", d_u, 64'h7FFF);
    send_and_get(64'h0007_0006_0005_0004, d_u, d_s, lat);
    chk("req023_uavg", d_u, 64'h5);

    // Backpressure: 5 words, downstream stalled 6 cycles
    do_clear();
    do_start(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) words[i] = {16'(i), 16'(i * 3 + 1), 16'(100 - i), 16'(i * 7)};
    dout_rdy = 1'b0;
    idx = 0;
    for (int c = 0; c < 60 && idx < 5; c++) begin
      if (c == 6) dout_rdy = 1'b1;
      din = words[idx]; din_vld = 1'b1;
      #1;
      acc = bus_u.DIN_RDY;
      tick();
      if (acc) idx++;
    end
    if (idx < 5) fail_now("req024_send");
    din_vld = 1'b0;
    dout_rdy = 1'b1;
    repeat (6) tick();
    chk("req024_cnt", bus_u.OUT_CNT, 64'd5);

    // Bypass
    do_clear();
    do_start(1'b0, 1'b0);
    din = 64'h1234_5678_9ABC_DEF0; din_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dout_rdy = i[0];
      #1;
      chk("req025_dout", bus_u.DOUT, 64'h1234_5678_9ABC_DEF0);
      chk("req025_rdy", bus_u.DIN_RDY, 64'(dout_rdy));
      tick();
    end
    chk("req025_cnt", bus_u.OUT_CNT, 64'd0);
    din_vld = 1'b0;

    // Clear wins over start; clear with words in flight
    do_clear();
    op_clear = 1'b1; op_start = 1'b1; pool_use = 1'b1; din_vld = 1'b1; dout_rdy = 1'b1;
    tick();
    op_clear = 1'b0; op_start = 1'b0;
    chk("req026_idle_rdy", bus_u.DIN_RDY, 64'd0);
    din_vld = 1'b0;
    do_start(1'b1, 1'b0);
    din = 64'h0011_0022_0033_0044; din_vld = 1'b1;
    tick();
    din = 64'h0055_0066_0077_0088;
    tick();
    din_vld = 1'b0; op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("req026_no_vld", bus_u.DOUT_VLD, 64'd0);
      tick();
    end

    // Reset mid-stream
    do_start(1'b1, 1'b0);
    dout_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = {$urandom, $urandom}; din_vld = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("req027_vld", bus_u.DOUT_VLD, 64'd0);
    chk("req027_rdy", bus_u.DIN_RDY, 64'd0);
    chk("req027_cnt", bus_s.OUT_CNT, 64'd0);
    tick();
    rst = 1'b0; dout_rdy = 1'b1;
    repeat (4) tick();
    chk("req027_after", bus_u.DOUT_VLD, 64'd0);
    din_vld = 1'b0;

    // Randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_clear();
      do_start($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 250; c++) begin
        din       = {$urandom, $urandom};
        din_vld   = $urandom_range(0, 3) != 0;
        dout_rdy  = $urandom_range(0, 2) != 0;
        op_clear  = $urandom_range(0, 79) == 0;
        op_start  = $urandom_range(0, 29) == 0;
        pool_use  = $urandom_range(0, 3) != 0;
        pool_mode = 1'($urandom_range(0, 1));
        rst       = (ep == 3) && (c == 120 || c == 121);
        tick();
      end
      op_clear = 1'b0; op_start = 1'b0; rst = 1'b0;
    end
    din_vld = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
